// File: rtl/disp_source_arbiter_if.sv
// Display-source arbiter bundle: source buses, controls and shared display pins.
// The master side feeds sources and controls; the slave side drives the display.
interface disp_source_arbiter_if #(
    parameter int NSRC   = 4,
    parameter int SEL_W  = 2,
    parameter int SEG_W  = 8,
    parameter int TUBE_W = 8
);
    logic                     power_on;
    logic [SEL_W-1:0]         src_sel;
    logic [NSRC-1:0]          blink_en;
    logic [NSRC*SEG_W-1:0]    digit1_bus;
    logic [NSRC*SEG_W-1:0]    digit2_bus;
    logic [NSRC*TUBE_W-1:0]   tube_sel_bus;
    logic [SEG_W-1:0]         digit1;
    logic [SEG_W-1:0]         digit2;
    logic [TUBE_W-1:0]        tube_sel;
    logic [SEL_W-1:0]         active_src;
    logic                     switching;

    modport master (
        output power_on, src_sel, blink_en,
        output digit1_bus, digit2_bus, tube_sel_bus,
        input  digit1, digit2, tube_sel, active_src, switching
    );

    modport slave (
        input  power_on, src_sel, blink_en,
        input  digit1_bus, digit2_bus, tube_sel_bus,
        output digit1, digit2, tube_sel, active_src, switching
    );
endinterface

// File: rtl/disp_source_arbiter.sv
// Selects one of NSRC seven-segment sources, blanks on source change,
// goes dark when powered off and optionally blinks the tubes.
module disp_source_arbiter #(
    parameter int NSRC         = 4,
    parameter int SEL_W        = 2,
    parameter int SEG_W        = 8,
    parameter int TUBE_W       = 8,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_HALF   = 50_000_000
) (
    input logic clk,
    input logic rst,
    disp_source_arbiter_if.slave bus
);
    localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int HCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BCW-1:0] BC_LAST = BCW'(BLANK_CYCLES - 1);
    localparam logic [HCW-1:0] HC_LAST = HCW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_active, w_active_nxt;
    logic [BCW-1:0]     r_blank, w_blank_nxt;
    logic [HCW-1:0]     r_blink, w_blink_nxt;
    logic               r_phase, w_phase_nxt;
    logic [SEG_W-1:0]   r_d1, w_d1_nxt;
    logic [SEG_W-1:0]   r_d2, w_d2_nxt;
    logic [TUBE_W-1:0]  r_tube, w_tube_nxt;
    logic               r_sw, w_sw_nxt;

    logic [SEL_W:0]     w_sel_x;
    logic [SEL_W-1:0]   w_eff;
    logic               w_change;
    logic [SEG_W-1:0]   w_src_d1, w_src_d2;
    logic [TUBE_W-1:0]  w_src_tube;

    // Out-of-range indices fall back to source 0.
    assign w_sel_x    = {1'b0, bus.src_sel};
    assign w_eff      = (w_sel_x < (SEL_W+1)'(NSRC)) ? bus.src_sel : '0;
    assign w_change   = (w_eff != r_active);
    assign w_src_d1   = bus.digit1_bus[int'(r_active)*SEG_W +: SEG_W];
    assign w_src_d2   = bus.digit2_bus[int'(r_active)*SEG_W +: SEG_W];
    assign w_src_tube = bus.tube_sel_bus[int'(r_active)*TUBE_W +: TUBE_W];

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_blank_nxt  = r_blank;
        w_blink_nxt  = r_blink;
        w_phase_nxt  = r_phase;
        w_d1_nxt     = '0;
        w_d2_nxt     = '0;
        w_tube_nxt   = '0;
        w_sw_nxt     = 1'b0;
        unique case (r_state)
            S_OFF: begin
                if (bus.power_on) begin
                    w_state_nxt  = S_BLANK;
                    w_active_nxt = w_eff;
                    w_blank_nxt  = BC_LAST;
                    w_sw_nxt     = 1'b1;
                end
            end
            S_BLANK: begin
                if (!bus.power_on) begin
                    w_state_nxt = S_OFF;
                end else if (w_change) begin
                    w_active_nxt = w_eff;
                    w_blank_nxt  = BC_LAST;
                    w_sw_nxt     = 1'b1;
                end else if (r_blank == '0) begin
                    w_state_nxt = S_SHOW;
                    w_blink_nxt = '0;
                    w_phase_nxt = 1'b1;
                    w_d1_nxt    = w_src_d1;
                    w_d2_nxt    = w_src_d2;
                    w_tube_nxt  = w_src_tube;
                end else begin
                    w_blank_nxt = r_blank - 1'b1;
                    w_sw_nxt    = 1'b1;
                end
            end
            S_SHOW: begin
                if (!bus.power_on) begin
                    w_state_nxt = S_OFF;
                end else if (w_change) begin
                    w_state_nxt  = S_BLANK;
                    w_active_nxt = w_eff;
                    w_blank_nxt  = BC_LAST;
                    w_sw_nxt     = 1'b1;
                end else begin
                    if (r_blink == HC_LAST) begin
                        w_blink_nxt = '0;
                        w_phase_nxt = ~r_phase;
                    end else begin
                        w_blink_nxt = r_blink + 1'b1;
                    end
                    w_d1_nxt = w_src_d1;
                    w_d2_nxt = w_src_d2;
                    // Blanking follows the phase being entered on this edge.
                    if (bus.blink_en[r_active] && !w_phase_nxt)
                        w_tube_nxt = '0;
                    else
                        w_tube_nxt = w_src_tube;
                end
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_OFF;
            r_active <= '0;
            r_blank  <= '0;
            r_blink  <= '0;
            r_phase  <= 1'b1;
            r_d1     <= '0;
            r_d2     <= '0;
            r_tube   <= '0;
            r_sw     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_blank  <= w_blank_nxt;
            r_blink  <= w_blink_nxt;
            r_phase  <= w_phase_nxt;
            r_d1     <= w_d1_nxt;
            r_d2     <= w_d2_nxt;
            r_tube   <= w_tube_nxt;
            r_sw     <= w_sw_nxt;
        end
    end

    assign bus.digit1     = r_d1;
    assign bus.digit2     = r_d2;
    assign bus.tube_sel   = r_tube;
    assign bus.active_src = r_active;
    assign bus.switching  = r_sw;
endmodule

// File: doc/disp_source_arbiter.md
# disp_source_arbiter

Parametrised display-source arbiter for the range-hood top level. It selects one of NSRC seven-segment sources (current time, smoker gear display, self-clean countdown, and others) and drives the shared digit1/digit2/tube_sel pins. It blanks the display for a fixed window whenever the source changes and forces the display dark when the machine is off. It can also blink the tubes of any source flagged for blinking. It replaces the single-cycle case mux previously written inline in the top level.

## Interface
Parameters:
- NSRC, 4: number of display sources; minimum 2.
- SEL_W, 2: width of source index; must satisfy 2^SEL_W ≥ NSRC.
- SEG_W, 8: segment bus width per digit group.
- TUBE_W, 8: tube-select width.
- BLANK_CYCLES, 1000: blank-window length in clk cycles; minimum 1.
- BLINK_HALF, 50_000_000: blink half-period in clk cycles; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- power_on  in  1  machine on/off state; 0 forces a dark display.
- src_sel  in  SEL_W  requested source index.
- blink_en  in  NSRC  per-source blink enable; bit k applies to source k.
- digit1_bus  in  NSRC*SEG_W  source k's digit1 at [k*SEG_W +: SEG_W].
- digit2_bus  in  NSRC*SEG_W  source k's digit2 at the same slicing.
- tube_sel_bus  in  NSRC*TUBE_W  source k's tube_sel at [k*TUBE_W +: TUBE_W].
- digit1  out  SEG_W  registered segment output.
- digit2  out  SEG_W  registered segment output.
- tube_sel  out  TUBE_W  registered tube-select output.
- active_src  out  SEL_W  index of the source currently latched.
- switching  out  1  high exactly while in BLANK.

## Operation
- FSM states: OFF, BLANK, SHOW.
- Reset value of every register:
  - state = OFF.
  - digit1, digit2, tube_sel = 0.
  - active_src = 0, switching = 0.
  - blank counter = 0, blink counter = 0, blink phase = 1 (visible).
- Effective select: eff_sel = src_sel if src_sel < NSRC, otherwise 0.
- Priority, highest first: rst, then power_on=0, then source change, then counter expiry.
- OFF:
  - All outputs are 0.
  - On power_on=1: go to BLANK, active_src ← eff_sel, blank counter ← BLANK_CYCLES-1.
- BLANK:
  - Outputs are 0 and switching=1.
  - If power_on=0: go to OFF.
  - Else if eff_sel ≠ active_src: active_src ← eff_sel and the blank counter restarts at BLANK_CYCLES-1.
  - Else if counter = 0: go to SHOW, load outputs from source active_src, blink counter ← 0, blink phase ← 1.
  - Else: decrement the counter.
- SHOW:
  - Each cycle, outputs register the active_src slices of the three buses.
  - If power_on=0: go to OFF; outputs become 0 on the same edge.
  - If eff_sel ≠ active_src: go to BLANK exactly as from OFF; outputs become 0 on the same edge.
  - Blink counter increments each SHOW cycle. When it reaches BLINK_HALF-1 it wraps to 0 and blink phase toggles.
  - When blink_en[active_src]=1 and phase=0, tube_sel is forced to 0; digit1/digit2 still pass through.
  - When blink_en[active_src]=0, tube_sel passes through regardless of phase.
  - Phase keeps toggling, so enabling blink mid-SHOW takes effect at the current phase.
- Data changes on the buses during SHOW never trigger blanking. Only an index change does.

## Timing
- Bus-to-output latency in SHOW: 1 cycle (bus value at edge n appears after edge n).
- src_sel change sampled at edge n:
  - switching=1 and outputs=0 from edge n through edge n+BLANK_CYCLES-1.
  - New source data appears after edge n+BLANK_CYCLES.
- power_on rising sampled at edge n: same window as a source change.
- power_on falling: outputs and switching are 0 after the very next edge.
- A source change inside BLANK extends the window to a full BLANK_CYCLES from that edge.
- Blink, entering SHOW at edge s:
  - Visible for BLINK_HALF cycles, then dark for BLINK_HALF cycles, repeating.
  - The first toggle occurs at edge s+BLINK_HALF.
- rst during any state takes effect on the next edge and overrides every input; all outputs read 0 after that edge.
- power_on and src_sel are synchronous, already-debounced levels. Outputs and active_src are glitch-free registers.

## Test plan
Bench parameters: NSRC=4, BLANK_CYCLES=4, BLINK_HALF=8.
- Reset then power-up: rst 2 cycles; power_on=1, src_sel=2, bus slice 2 = 8'hA5/8'h3C/8'h0F.
  - Required: outputs 0 and switching=1 for 4 cycles.
  - Then digit1=A5, digit2=3C, tube_sel=0F, active_src=2.
- Source change in SHOW: src_sel 2→1.
  - Required: 4 zero cycles with switching=1, then slice 1 data.
  - A second change to 3 during blank gives a fresh 4-cycle window from that edge.
- Power-off mid-SHOW: power_on→0.
  - Required: all outputs 0 after one edge; state OFF; active_src unchanged.
- Blink: blink_en=4'b0100, source 2 shown.
  - Required: tube_sel = 0F for 8 cycles, 00 for 8 cycles, repeating; digit1 stays A5 throughout.
  - With blink_en=0, tube_sel stays 0F continuously.
- Out-of-range select: with NSRC=3, SEL_W=2, src_sel=3.
  - Required: active_src=0 and source 0 displayed after the blank window.
- Synchronous reset mid-BLANK: rst=1 during cycle 2 of the window.
  - Required: all outputs 0, switching=0, active_src=0 after that edge.
  - Reset is not honoured asynchronously: no output change before the edge.
